vector_result_writeback: RTL and testbench

- Sits at the consumer end of the vector function unit's result interface.
- Records per-instruction destination metadata at issue and samples the unit's `result` when the unit's status reports FINISHED.
- Merges the result with the old destination value under mask and vl rules, then writes the merged vector to the vector register file in fixed-width beats.
- Serialises completion back to the issue stage.

---
 rtl/vector_result_writeback_pkg.sv | 32 +++
 rtl/vector_wb_meta_fifo.sv | 55 +++++
 rtl/vector_result_writeback.sv | 188 ++++++++++++++++++
 tb/tb_vector_result_writeback.sv | 322 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vector_result_writeback_pkg.sv
// Shared codes for the vector result writeback block: function-unit status,
// element-width encodings and writeback FSM states.
package vector_result_writeback_pkg;

    typedef enum logic [1:0] {
        VEC_ALU_NOP      = 2'd0,
        VEC_ALU_WORKING  = 2'd1,
        VEC_ALU_FINISHED = 2'd2
    } vec_alu_status_e;

    localparam logic [2:0] ONE_BYTE   = 3'd0;
    localparam logic [2:0] TWO_BYTE   = 3'd1;
    localparam logic [2:0] FOUR_BYTE  = 3'd2;
    localparam logic [2:0] EIGHT_BYTE = 3'd3;

    typedef enum logic [1:0] {
        WB_IDLE  = 2'd0,
        WB_MERGE = 2'd1,
        WB_WRITE = 2'd2
    } wb_state_e;

    // log2(bytes per element); unknown codes fall back to byte elements
    function automatic logic [1:0] eew_shift(input logic [2:0] eew);
        case (eew)
            TWO_BYTE:   return 2'd1;
            FOUR_BYTE:  return 2'd2;
            EIGHT_BYTE: return 2'd3;
            default:    return 2'd0;
        endcase
    endfunction

endpackage

// File: rtl/vector_wb_meta_fifo.sv
// Small FIFO holding per-instruction destination metadata between issue and
// result completion. Pointers wrap modulo META_DEPTH.
module vector_wb_meta_fifo #(
    parameter int META_DEPTH = 2,
    parameter int PAYLOAD_W  = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 i_push,
    input  logic [PAYLOAD_W-1:0] i_din,
    input  logic                 i_pop,
    output logic [PAYLOAD_W-1:0] o_head,
    output logic                 o_full,
    output logic                 o_empty
);

    localparam int PTR_W = (META_DEPTH > 1) ? $clog2(META_DEPTH) : 1;
    localparam int CNT_W = $clog2(META_DEPTH + 1);

    logic [PAYLOAD_W-1:0] r_mem [META_DEPTH];
    logic [PTR_W-1:0]     r_wr_ptr;
    logic [PTR_W-1:0]     r_rd_ptr;
    logic [CNT_W-1:0]     r_count;

    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] ptr);
        if (ptr == PTR_W'(META_DEPTH - 1)) return '0;
        return ptr + 1'b1;
    endfunction

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (i_push) r_wr_ptr <= next_ptr(r_wr_ptr);
            if (i_pop)  r_rd_ptr <= next_ptr(r_rd_ptr);
            // simultaneous push and pop leaves occupancy unchanged
            case ({i_push, i_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (i_push) r_mem[r_wr_ptr] <= i_din;
    end

    assign o_head  = r_mem[r_rd_ptr];
    assign o_full  = (r_count == CNT_W'(META_DEPTH));
    assign o_empty = (r_count == '0);

endmodule

// File: rtl/vector_result_writeback.sv
// Consumer end of the vector function unit: merges each finished result with the
// old destination under mask/vl rules and writes it to the register file in beats.
module vector_result_writeback
    import vector_result_writeback_pkg::*;
#(
    parameter int LEN             = 32,
    parameter int VECTOR_SIZE     = 8,
    parameter int WB_WIDTH        = 64,
    parameter int VREG_INDEX_SIZE = 5,
    parameter int META_DEPTH      = 2,
    localparam int VLEN           = VECTOR_SIZE * LEN,
    localparam int BEATS          = VLEN / WB_WIDTH,
    localparam int BEAT_W         = (BEATS > 1) ? $clog2(BEATS) : 1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       rdy_in,
    input  logic                       issue,
    output logic                       issue_ready,
    input  logic [VREG_INDEX_SIZE-1:0] issue_vd,
    input  logic                       issue_vm,
    input  logic [VLEN-1:0]            issue_mask,
    input  logic [LEN-1:0]             issue_length,
    input  logic [2:0]                 issue_eew,
    input  logic [VLEN-1:0]            issue_old_vd,
    input  logic [1:0]                 vector_alu_status,
    input  logic                       is_mask,
    input  logic [VLEN-1:0]            result,
    output logic                       vreg_wr_en,
    output logic [VREG_INDEX_SIZE-1:0] vreg_wr_index,
    output logic [BEAT_W-1:0]          vreg_wr_beat,
    output logic [WB_WIDTH-1:0]        vreg_wr_data,
    output logic                       wb_done,
    output logic                       busy,
    output logic                       error
);

    localparam int NBYTES = VLEN / 8;
    localparam int IDX_W  = $clog2(VLEN);

    typedef struct packed {
        logic [VREG_INDEX_SIZE-1:0] vd;
        logic                       vm;
        logic [VLEN-1:0]            mask;
        logic [LEN-1:0]             length;
        logic [2:0]                 eew;
        logic [VLEN-1:0]            old_vd;
    } meta_t;

    localparam int META_W = $bits(meta_t);

    wb_state_e             r_state;
    logic [BEAT_W-1:0]     r_beat;
    logic                  r_error;
    meta_t                 r_meta;
    logic [VLEN-1:0]       r_result;
    logic                  r_is_mask;
    logic [VLEN-1:0]       r_wbuf;

    logic                  w_push;
    logic                  w_pop;
    logic                  w_full;
    logic                  w_empty;
    logic                  w_finished;
    logic                  w_issue_valid;
    logic [META_W-1:0]     w_head;
    meta_t                 w_issue_meta;
    logic [VLEN-1:0]       w_merged;
    logic [1:0]            w_shift;
    logic [IDX_W-1:0]      w_eidx;
    logic                  w_wr_en;
    logic                  w_last_beat;
    logic [WB_WIDTH-1:0]   w_beat_data;

    assign w_finished    = (vector_alu_status == VEC_ALU_FINISHED);
    assign w_issue_valid = issue && (issue_length != '0);
    assign w_push        = w_issue_valid && !w_full;
    assign w_pop         = (r_state == WB_IDLE) && w_finished && !w_empty;

    assign w_issue_meta = '{
        vd:     issue_vd,
        vm:     issue_vm,
        mask:   issue_mask,
        length: issue_length,
        eew:    issue_eew,
        old_vd: issue_old_vd
    };

    vector_wb_meta_fifo #(
        .META_DEPTH (META_DEPTH),
        .PAYLOAD_W  (META_W)
    ) u_meta_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_push),
        .i_din   (w_issue_meta),
        .i_pop   (w_pop),
        .o_head  (w_head),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    // Control path: FSM, beat counter and sticky protocol error
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= WB_IDLE;
            r_beat  <= '0;
            r_error <= 1'b0;
        end else begin
            if ((w_issue_valid && w_full) ||
                (w_finished && ((r_state != WB_IDLE) || w_empty))) begin
                r_error <= 1'b1;
            end
            case (r_state)
                WB_IDLE: begin
                    if (w_pop) r_state <= WB_MERGE;
                end
                WB_MERGE: begin
                    r_state <= WB_WRITE;
                    r_beat  <= '0;
                end
                WB_WRITE: begin
                    if (rdy_in) begin
                        if (w_last_beat) begin
                            r_state <= WB_IDLE;
                            r_beat  <= '0;
                        end else begin
                            r_beat <= r_beat + 1'b1;
                        end
                    end
                end
                default: r_state <= WB_IDLE;
            endcase
        end
    end

    // Data path: captured result, working metadata and merged write buffer
    always_ff @(posedge clk) begin
        if (w_pop) begin
            r_result  <= result;
            r_is_mask <= is_mask;
            r_meta    <= meta_t'(w_head);
        end
        if (r_state == WB_MERGE) r_wbuf <= w_merged;
    end

    // Inactive and tail elements stay undisturbed; byte k of the vector belongs
    // to element k>>shift, so the VLEN/E cap on the element count is implicit.
    always_comb begin
        w_merged = r_meta.old_vd;
        w_shift  = eew_shift(r_meta.eew);
        w_eidx   = '0;
        if (r_is_mask) begin
            for (int b = 0; b < VLEN; b++) begin
                if ((LEN'(b) < r_meta.length) && (r_meta.vm || r_meta.mask[b])) begin
                    w_merged[b] = r_result[b];
                end
            end
        end else begin
            for (int k = 0; k < NBYTES; k++) begin
                w_eidx = IDX_W'(k) >> w_shift;
                if ((LEN'(w_eidx) < r_meta.length) && (r_meta.vm || r_meta.mask[w_eidx])) begin
                    w_merged[k*8 +: 8] = r_result[k*8 +: 8];
                end
            end
        end
    end

    always_comb begin
        w_beat_data = '0;
        for (int k = 0; k < BEATS; k++) begin
            if (r_beat == BEAT_W'(k)) w_beat_data = r_wbuf[k*WB_WIDTH +: WB_WIDTH];
        end
    end

    assign w_last_beat   = (r_beat == BEAT_W'(BEATS - 1));
    assign w_wr_en       = (r_state == WB_WRITE) && rdy_in;

    assign vreg_wr_en    = w_wr_en;
    assign vreg_wr_index = (r_state == WB_WRITE) ? r_meta.vd : '0;
    assign vreg_wr_beat  = r_beat;
    assign vreg_wr_data  = (r_state == WB_WRITE) ? w_beat_data : '0;
    assign wb_done       = w_wr_en && w_last_beat;
    assign busy          = (r_state != WB_IDLE);
    assign issue_ready   = !w_full;
    assign error         = r_error;

endmodule

// File: tb/tb_vector_result_writeback.sv
// Directed bench for vector_result_writeback: one task per scenario with
// hand-computed expected beats, flags and status.
module tb_vector_result_writeback;
    import vector_result_writeback_pkg::*;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         rdy_in = 1'b1;
    logic         issue = 1'b0;
    logic         issue_ready;
    logic [4:0]   issue_vd = '0;
    logic         issue_vm = 1'b0;
    logic [255:0] issue_mask = '0;
    logic [31:0]  issue_length = '0;
    logic [2:0]   issue_eew = '0;
    logic [255:0] issue_old_vd = '0;
    logic [1:0]   vector_alu_status = VEC_ALU_NOP;
    logic         is_mask = 1'b0;
    logic [255:0] result = '0;
    logic         vreg_wr_en;
    logic [4:0]   vreg_wr_index;
    logic [1:0]   vreg_wr_beat;
    logic [63:0]  vreg_wr_data;
    logic         wb_done;
    logic         busy;
    logic         error;

    int n_pass  = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    vector_result_writeback dut (
        .clk               (clk),
        .rst               (rst),
        .rdy_in            (rdy_in),
        .issue             (issue),
        .issue_ready       (issue_ready),
        .issue_vd          (issue_vd),
        .issue_vm          (issue_vm),
        .issue_mask        (issue_mask),
        .issue_length      (issue_length),
        .issue_eew         (issue_eew),
        .issue_old_vd      (issue_old_vd),
        .vector_alu_status (vector_alu_status),
        .is_mask           (is_mask),
        .result            (result),
        .vreg_wr_en        (vreg_wr_en),
        .vreg_wr_index     (vreg_wr_index),
        .vreg_wr_beat      (vreg_wr_beat),
        .vreg_wr_data      (vreg_wr_data),
        .wb_done           (wb_done),
        .busy              (busy),
        .error             (error)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_issue(input logic [4:0] vd, input logic vm, input logic [255:0] mask,
                            input logic [31:0] len, input logic [2:0] eew, input logic [255:0] old);
        issue = 1'b1; issue_vd = vd; issue_vm = vm; issue_mask = mask;
        issue_length = len; issue_eew = eew; issue_old_vd = old;
        tick();
        issue = 1'b0;
    endtask

    task automatic fire(input logic [255:0] res, input logic msk);
        vector_alu_status = VEC_ALU_FINISHED; result = res; is_mask = msk;
        tick();
        vector_alu_status = VEC_ALU_NOP; result = '0; is_mask = 1'b0;
    endtask

    task automatic apply_reset();
        rst = 1'b0;
        tick();
        rst = 1'b1;
        tick();
    endtask

    task automatic test_reset();
        rst = 1'b0;
        tick();
        n_total++;
        if ({vreg_wr_en, vreg_wr_index, vreg_wr_beat, vreg_wr_data, wb_done, busy, error, issue_ready}
            !== {1'b0, 5'd0, 2'd0, 64'd0, 1'b0, 1'b0, 1'b0, 1'b1})
            $display("FAIL reset_outputs got en=%b idx=%0d beat=%0d data=%h done=%b busy=%b err=%b rdy=%b want all 0, issue_ready=1",
                     vreg_wr_en, vreg_wr_index, vreg_wr_beat, vreg_wr_data, wb_done, busy, error, issue_ready);
        else n_pass++;
        rst = 1'b1;
        tick();
    endtask

    task automatic test_unmasked();
        logic [255:0] res;
        for (int i = 0; i < 8; i++) res[i*32 +: 32] = 32'h11111111 * (i + 1);
        do_issue(5'd5, 1'b1, '0, 32'd8, FOUR_BYTE, {256{1'b1}});
        fire(res, 1'b0);
        n_total++;
        if ({vreg_wr_en, busy} !== 2'b01)
            $display("FAIL unmasked_merge_cycle got en=%b busy=%b want en=0 busy=1", vreg_wr_en, busy);
        else n_pass++;
        for (int k = 0; k < 4; k++) begin
            tick();
            n_total++;
            if ({vreg_wr_en, vreg_wr_index, vreg_wr_beat, vreg_wr_data, wb_done}
                !== {1'b1, 5'd5, 2'(k), res[k*64 +: 64], (k == 3)})
                $display("FAIL unmasked_beat%0d got en=%b idx=%0d beat=%0d data=%h done=%b want data=%h",
                         k, vreg_wr_en, vreg_wr_index, vreg_wr_beat, vreg_wr_data, wb_done, res[k*64 +: 64]);
            else n_pass++;
        end
        tick();
        n_total++;
        if ({vreg_wr_en, busy, error} !== 3'b000)
            $display("FAIL unmasked_idle got en=%b busy=%b err=%b want 000", vreg_wr_en, busy, error);
        else n_pass++;
    endtask

    task automatic test_tail_mask();
        logic [63:0] exp_b [4];
        exp_b[0] = 64'hAAAAAA01_AA0101AA;
        exp_b[1] = {8{8'hAA}};
        exp_b[2] = {8{8'hAA}};
        exp_b[3] = {8{8'hAA}};
        do_issue(5'd9, 1'b0, 256'b10110, 32'd5, ONE_BYTE, {32{8'hAA}});
        fire({32{8'h01}}, 1'b0);
        for (int k = 0; k < 4; k++) begin
            tick();
            n_total++;
            if ({vreg_wr_en, vreg_wr_index, vreg_wr_data} !== {1'b1, 5'd9, exp_b[k]})
                $display("FAIL tail_mask_beat%0d got en=%b idx=%0d data=%h want data=%h",
                         k, vreg_wr_en, vreg_wr_index, vreg_wr_data, exp_b[k]);
            else n_pass++;
        end
        tick();
    endtask

    task automatic test_mask_result();
        logic [63:0] exp_b [4];
        exp_b[0] = 64'hFFFFFFFF_FFFFFD55;
        exp_b[1] = '1;
        exp_b[2] = '1;
        exp_b[3] = '1;
        do_issue(5'd2, 1'b1, '0, 32'd10, ONE_BYTE, {256{1'b1}});
        fire(256'h155, 1'b1);
        for (int k = 0; k < 4; k++) begin
            tick();
            n_total++;
            if ({vreg_wr_en, vreg_wr_index, vreg_wr_data} !== {1'b1, 5'd2, exp_b[k]})
                $display("FAIL mask_result_beat%0d got en=%b idx=%0d data=%h want data=%h",
                         k, vreg_wr_en, vreg_wr_index, vreg_wr_data, exp_b[k]);
            else n_pass++;
        end
        tick();
    endtask

    task automatic test_stall();
        logic [63:0] exp_b [4];
        exp_b[0] = {8{8'h55}};
        exp_b[1] = {8{8'h55}};
        exp_b[2] = {8{8'h55}};
        exp_b[3] = 64'd0;
        do_issue(5'd12, 1'b1, '0, 32'd3, EIGHT_BYTE, '0);
        fire({32{8'h55}}, 1'b0);
        tick();
        n_total++;
        if ({vreg_wr_en, vreg_wr_beat, vreg_wr_data} !== {1'b1, 2'd0, exp_b[0]})
            $display("FAIL stall_beat0 got en=%b beat=%0d data=%h want en=1 beat=0 data=%h",
                     vreg_wr_en, vreg_wr_beat, vreg_wr_data, exp_b[0]);
        else n_pass++;
        tick();
        for (int s = 0; s < 3; s++) begin
            rdy_in = 1'b0;
            #1;
            n_total++;
            if ({vreg_wr_en, vreg_wr_beat, wb_done, busy} !== {1'b0, 2'd1, 1'b0, 1'b1})
                $display("FAIL stall_hold%0d got en=%b beat=%0d done=%b busy=%b want en=0 beat=1 done=0 busy=1",
                         s, vreg_wr_en, vreg_wr_beat, wb_done, busy);
            else n_pass++;
            tick();
        end
        rdy_in = 1'b1;
        #1;
        for (int k = 1; k < 4; k++) begin
            n_total++;
            if ({vreg_wr_en, vreg_wr_index, vreg_wr_beat, vreg_wr_data, wb_done}
                !== {1'b1, 5'd12, 2'(k), exp_b[k], (k == 3)})
                $display("FAIL stall_resume_beat%0d got en=%b idx=%0d beat=%0d data=%h done=%b want data=%h",
                         k, vreg_wr_en, vreg_wr_index, vreg_wr_beat, vreg_wr_data, wb_done, exp_b[k]);
            else n_pass++;
            tick();
        end
        n_total++;
        if ({busy, vreg_wr_en} !== 2'b00)
            $display("FAIL stall_idle got busy=%b en=%b want 00", busy, vreg_wr_en);
        else n_pass++;
    endtask

    task automatic test_fifo_order();
        do_issue(5'd3, 1'b1, '0, 32'd4, FOUR_BYTE, '0);
        n_total++;
        if ({issue_ready, error} !== 2'b10)
            $display("FAIL fifo_one_entry got ready=%b err=%b want ready=1 err=0", issue_ready, error);
        else n_pass++;
        do_issue(5'd7, 1'b1, '0, 32'd8, FOUR_BYTE, '0);
        n_total++;
        if ({issue_ready, error} !== 2'b00)
            $display("FAIL fifo_full got ready=%b err=%b want ready=0 err=0", issue_ready, error);
        else n_pass++;
        do_issue(5'd9, 1'b1, '0, 32'd8, FOUR_BYTE, '0);
        n_total++;
        if ({issue_ready, error} !== 2'b01)
            $display("FAIL fifo_overflow got ready=%b err=%b want ready=0 err=1", issue_ready, error);
        else n_pass++;
        fire({32{8'h33}}, 1'b0);
        n_total++;
        if (issue_ready !== 1'b1)
            $display("FAIL fifo_after_pop got ready=%b want 1", issue_ready);
        else n_pass++;
        for (int k = 0; k < 4; k++) begin
            tick();
            n_total++;
            if ({vreg_wr_en, vreg_wr_index, vreg_wr_data} !== {1'b1, 5'd3, (k < 2) ? {8{8'h33}} : 64'd0})
                $display("FAIL fifo_first_beat%0d got en=%b idx=%0d data=%h want idx=3",
                         k, vreg_wr_en, vreg_wr_index, vreg_wr_data);
            else n_pass++;
        end
        tick();
        fire({32{8'h77}}, 1'b0);
        for (int k = 0; k < 4; k++) begin
            tick();
            n_total++;
            if ({vreg_wr_en, vreg_wr_index, vreg_wr_data} !== {1'b1, 5'd7, {8{8'h77}}})
                $display("FAIL fifo_second_beat%0d got en=%b idx=%0d data=%h want idx=7 data=%h",
                         k, vreg_wr_en, vreg_wr_index, vreg_wr_data, {8{8'h77}});
            else n_pass++;
        end
        tick();
    endtask

    task automatic test_reset_mid_write();
        do_issue(5'd4, 1'b1, '0, 32'd8, FOUR_BYTE, '0);
        do_issue(5'd6, 1'b1, '0, 32'd8, FOUR_BYTE, '0);
        fire({32{8'hC3}}, 1'b0);
        do_issue(5'd8, 1'b1, '0, 32'd8, FOUR_BYTE, '0);
        tick();
        tick();
        n_total++;
        if ({vreg_wr_en, vreg_wr_beat, issue_ready, error} !== {1'b1, 2'd2, 1'b0, 1'b1})
            $display("FAIL midwrite_pre got en=%b beat=%0d ready=%b err=%b want en=1 beat=2 ready=0 err=1",
                     vreg_wr_en, vreg_wr_beat, issue_ready, error);
        else n_pass++;
        #2;
        rst = 1'b0;
        #1;
        n_total++;
        if ({vreg_wr_en, wb_done, busy, issue_ready, error} !== 5'b00010)
            $display("FAIL midwrite_async_reset got en=%b done=%b busy=%b ready=%b err=%b want 00010",
                     vreg_wr_en, wb_done, busy, issue_ready, error);
        else n_pass++;
        tick();
        rst = 1'b1;
        tick();
        fire({32{8'h5A}}, 1'b0);
        n_total++;
        if ({error, busy} !== 2'b10)
            $display("FAIL reset_flushes_fifo got err=%b busy=%b want err=1 busy=0", error, busy);
        else n_pass++;
        apply_reset();
    endtask

    task automatic test_zero_length();
        do_issue(5'd1, 1'b1, '0, 32'd0, FOUR_BYTE, '0);
        n_total++;
        if ({issue_ready, error} !== 2'b10)
            $display("FAIL zero_len_issue got ready=%b err=%b want ready=1 err=0", issue_ready, error);
        else n_pass++;
        fire({32{8'hEE}}, 1'b0);
        tick();
        n_total++;
        if ({error, busy, vreg_wr_en} !== 3'b100)
            $display("FAIL zero_len_finish got err=%b busy=%b en=%b want 100", error, busy, vreg_wr_en);
        else n_pass++;
        apply_reset();
    endtask

    task automatic test_overrun();
        do_issue(5'd10, 1'b1, '0, 32'd8, FOUR_BYTE, '0);
        fire({32{8'h21}}, 1'b0);
        fire({32{8'hDE}}, 1'b0);
        n_total++;
        if ({vreg_wr_en, vreg_wr_index, vreg_wr_data, error} !== {1'b1, 5'd10, {8{8'h21}}, 1'b1})
            $display("FAIL overrun got en=%b idx=%0d data=%h err=%b want en=1 idx=10 data=%h err=1",
                     vreg_wr_en, vreg_wr_index, vreg_wr_data, error, {8{8'h21}});
        else n_pass++;
        tick();
        tick();
        tick();
        n_total++;
        if ({vreg_wr_beat, wb_done} !== {2'd3, 1'b1})
            $display("FAIL overrun_done got beat=%0d done=%b want beat=3 done=1", vreg_wr_beat, wb_done);
        else n_pass++;
        tick();
    endtask

    initial begin
        test_reset();
        test_unmasked();
        test_tail_mask();
        test_mask_result();
        test_stall();
        test_fifo_order();
        test_reset_mid_write();
        test_zero_length();
        test_overrun();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
